run_ctrl: RTL and testbench

Synthesizable program-load and run controller that sits between a byte-stream program source, an instruction memory it owns, and one processor core. It packs little-endian bytes into 16-bit instruction words, holds the core in reset during load, then runs it with a clock enable. It stops the core on a halt pin, on the PC leaving the loaded program, on an abort, or on a watchdog timeout, and reports the cause and the cycle count.

---
 rtl/run_ctrl_pkg.sv | 23 ++
 rtl/run_ctrl_ld_packer.sv | 75 +++++++
 rtl/run_ctrl.sv | 147 ++++++++++++++
 tb/tb_run_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and widths for the program-load / run controller.
package run_ctrl_pkg;

    localparam int BYTE_W  = 8;
    localparam int INSTR_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        PRST   = 3'd2,
        RUN    = 3'd3,
        HALTED = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_PIN     = 3'd1,
        CAUSE_OOB     = 3'd2,
        CAUSE_TIMEOUT = 3'd3,
        CAUSE_ABORT   = 3'd4
    } cause_t;

endpackage

// File: rtl/run_ctrl_ld_packer.sv
// ld_packer: packs a little-endian byte stream into 16-bit words, generates
// write strobes into instruction memory, counts words and flags overflow.
module ld_packer
    import run_ctrl_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     accept,
    input  logic [BYTE_W-1:0]        data,
    input  logic                     last,
    output logic                     wr_en,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [INSTR_W-1:0]       wr_data,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    logic              phase_q, phase_d;
    logic [BYTE_W-1:0] low_q, low_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              full;

    assign full       = (cnt_q == FULL);
    assign wr_addr    = cnt_q[AW-1:0];
    assign word_count = cnt_q;
    assign ovf        = ovf_q;

    // Byte assembly: even byte is parked, odd byte (or a lone last byte) writes a word.
    always_comb begin
        phase_d = phase_q;
        low_d   = low_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        wr_data = phase_q ? {data, low_q} : {8'h00, data};
        if (clear) begin
            phase_d = 1'b0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            if (full) begin
                ovf_d = 1'b1;
            end else if (phase_q || last) begin
                wr_en   = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                phase_d = 1'b0;
            end else begin
                low_d   = data;
                phase_d = 1'b1;
            end
        end
    end

    // Packer state; the parked low byte is pure data and needs no reset.
    always_ff @(posedge clk) begin
        low_q <= low_d;
        if (rst) begin
            phase_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: loads a program into owned instruction memory, then runs one core
// with a clock enable until halt pin, PC out of program, abort or watchdog.
// Optional watchdog: define RUN_CTRL_TIMEOUT_EN to build the TIMEOUT halt.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int PC_W     = 16,
    parameter int PIN_W    = 16,
    parameter int HALT_PIN = 1,
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic                   ld_valid,
    input  logic [7:0]             ld_data,
    input  logic                   ld_last,
    output logic                   ld_ready,
    input  logic                   run_start,
    input  logic                   run_abort,
    input  logic [PC_W-1:0]        proc_pc,
    input  logic [PIN_W-1:0]       proc_pins,
    output logic [15:0]            proc_ins,
    output logic                   proc_rst,
    output logic                   proc_en,
    output logic [2:0]             state,
    output logic [2:0]             halt_cause,
    output logic [CNT_W-1:0]       cycles,
    output logic [$clog2(DEPTH):0] prog_len,
    output logic                   load_ovf
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int CMP_W = (PC_W > LW) ? PC_W : LW;
    localparam logic [PC_W:0] DEPTH_X = (PC_W + 1)'(DEPTH);

    state_t             state_q, state_d;
    logic               ld_ready_q, proc_rst_q;
    cause_t             cause_q, cause_d, cause_sel;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               load_entry, prst_entry, accept;
    logic               halt_cond, oob, tmo;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [INSTR_W-1:0] wr_data;
    logic [INSTR_W-1:0] mem [DEPTH];

    assign accept     = ld_valid && ld_ready_q;
    assign load_entry = (state_q != LOAD) && (state_d == LOAD);
    assign prst_entry = (state_q != PRST) && (state_d == PRST);

    ld_packer #(.DEPTH(DEPTH)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (load_entry),
        .accept     (accept),
        .data       (ld_data),
        .last       (ld_last),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .word_count (prog_len),
        .ovf        (load_ovf)
    );

    // Instruction memory write port; contents survive reset and reloads.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign proc_ins = ({1'b0, proc_pc} < DEPTH_X) ? mem[proc_pc[AW-1:0]] : 16'h0000;

    assign oob = CMP_W'(proc_pc) >= CMP_W'(prog_len);
`ifdef RUN_CTRL_TIMEOUT_EN
    assign tmo = (cycles_q == CNT_W'(TIMEOUT));
`else
    localparam int unused_timeout = TIMEOUT;
    assign tmo = 1'b0;
`endif

    assign halt_cond = run_abort || proc_pins[HALT_PIN] || oob || tmo;
    assign proc_en   = (state_q == RUN) && !halt_cond;

    // Halt cause priority: abort, then halt pin, then out-of-program, then watchdog.
    always_comb begin
        cause_sel = CAUSE_NONE;
        if (run_abort)                cause_sel = CAUSE_ABORT;
        else if (proc_pins[HALT_PIN]) cause_sel = CAUSE_PIN;
        else if (oob)                 cause_sel = CAUSE_OOB;
        else if (tmo)                 cause_sel = CAUSE_TIMEOUT;
    end

    // Next state; load_start has priority over run_start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, HALTED: begin
                if (load_start)     state_d = LOAD;
                else if (run_start) state_d = PRST;
            end
            LOAD:    if (accept && ld_last) state_d = IDLE;
            PRST:    state_d = RUN;
            RUN:     if (halt_cond) state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // Run statistics: cleared when a run begins, cause latched on the halting edge.
    always_comb begin
        cycles_d = cycles_q;
        cause_d  = cause_q;
        if (prst_entry) begin
            cycles_d = '0;
            cause_d  = CAUSE_NONE;
        end else begin
            if (proc_en && (cycles_q != '1)) cycles_d = cycles_q + 1'b1;
            if ((state_q == RUN) && halt_cond) cause_d = cause_sel;
        end
    end

    // Controller FSM with registered handshake and core-reset outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ld_ready_q <= 1'b0;
            proc_rst_q <= 1'b1;
            cause_q    <= CAUSE_NONE;
            cycles_q   <= '0;
        end else begin
            state_q    <= state_d;
            ld_ready_q <= (state_d == LOAD);
            proc_rst_q <= (state_d == IDLE) || (state_d == LOAD) || (state_d == PRST);
            cause_q    <= cause_d;
            cycles_q   <= cycles_d;
        end
    end

    assign state      = state_q;
    assign ld_ready   = ld_ready_q;
    assign proc_rst   = proc_rst_q;
    assign halt_cause = cause_q;
    assign cycles     = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: scoreboard bench for run_ctrl (16-word memory, watchdog limit 8).
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int DEPTH = 16;
    localparam int TMO   = 8;
`ifdef RUN_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, load_start, ld_valid, ld_last, run_start, run_abort;
    logic [7:0]  ld_data;
    logic [15:0] proc_pc, proc_pins, proc_ins;
    logic        ld_ready, proc_rst, proc_en, load_ovf;
    logic [2:0]  state, halt_cause;
    logic [31:0] cycles;
    logic [4:0]  prog_len;

    run_ctrl #(.DEPTH(DEPTH), .PC_W(16), .PIN_W(16), .HALT_PIN(1), .CNT_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .run_start(run_start), .run_abort(run_abort),
        .proc_pc(proc_pc), .proc_pins(proc_pins), .proc_ins(proc_ins), .proc_rst(proc_rst),
        .proc_en(proc_en), .state(state), .halt_cause(halt_cause), .cycles(cycles),
        .prog_len(prog_len), .load_ovf(load_ovf)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          plen_m  = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  bq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop(input logic [31:0] got);
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    // Load the bytes in bq; model expects ceil(n/2) words capped at DEPTH.
    task automatic load_bytes();
        int n, words;
        n     = bq.size();
        words = (n + 1) / 2;
        plen_m = (words > DEPTH) ? DEPTH : words;
        sb_push("ld_ready", 32'd1);
        sb_push("ld_state_end", 32'(IDLE));
        sb_push("prog_len", 32'(plen_m));
        sb_push("load_ovf", (n > 2 * DEPTH) ? 32'd1 : 32'd0);
        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        sb_pop(32'(ld_ready));
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1; ld_data = bq[i]; ld_last = (i == n - 1);
            @(negedge clk);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        sb_pop(32'(state));
        sb_pop(32'(prog_len));
        sb_pop(32'(load_ovf));
    endtask

    task automatic read_word(input int pc, input logic [15:0] exp);
        sb_push("proc_ins", 32'(exp));
        proc_pc = pc[15:0];
        #1 sb_pop(32'(proc_ins));
    endtask

    // Run the core model: PC steps on committed cycles when inc is set.
    task automatic run_prog(input bit inc, input int pin_k, input int abort_k, input int limit);
        int pc_m, cnt_m;
        bit halted;
        logic [2:0] cause_m;
        @(negedge clk); proc_pc = '0; run_start = 1'b1;
        @(negedge clk); run_start = 1'b0;
        chk("prst_state", 32'(state), 32'(PRST));
        chk("prst_rst", 32'(proc_rst), 32'd1);
        chk("prst_cycles", cycles, 32'd0);
        pc_m = 0; cnt_m = 0; halted = 1'b0; cause_m = CAUSE_NONE;
        for (int k = 0; k < limit && !halted; k++) begin
            @(negedge clk);
            if (k == abort_k)                    cause_m = CAUSE_ABORT;
            else if (k == pin_k)                 cause_m = CAUSE_PIN;
            else if (pc_m >= plen_m)             cause_m = CAUSE_OOB;
            else if (TMO_EN && cnt_m == TMO)     cause_m = CAUSE_TIMEOUT;
            halted = (cause_m != CAUSE_NONE);
            sb_push("run_state", 32'(RUN));
            sb_push("run_en", halted ? 32'd0 : 32'd1);
            proc_pc   = pc_m[15:0];
            proc_pins = (k == pin_k) ? 16'h0002 : 16'h0000;
            run_abort = (k == abort_k);
            #1;
            sb_pop(32'(state));
            sb_pop(32'(proc_en));
            @(posedge clk); #1;
            proc_pins = '0; run_abort = 1'b0;
            if (!halted) begin
                cnt_m++;
                if (inc) pc_m++;
            end
        end
        sb_push("end_state", halted ? 32'(HALTED) : 32'(RUN));
        sb_push("halt_cause", 32'(cause_m));
        sb_push("cycles", 32'(cnt_m));
        @(negedge clk);
        sb_pop(32'(state));
        sb_pop(32'(halt_cause));
        sb_pop(32'(cycles));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; load_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
        run_start = 0; run_abort = 0; proc_pc = '0; proc_pins = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        chk("rst_state", 32'(state), 32'(IDLE));
        chk("rst_ld_ready", 32'(ld_ready), 32'd0);
        chk("rst_proc_rst", 32'(proc_rst), 32'd1);
        chk("rst_proc_en", 32'(proc_en), 32'd0);
        chk("rst_cause", 32'(halt_cause), 32'd0);
        chk("rst_cycles", cycles, 32'd0);
        chk("rst_prog_len", 32'(prog_len), 32'd0);
        chk("rst_ovf", 32'(load_ovf), 32'd0);

        bq = '{8'h01, 8'h02, 8'h03, 8'h04};
        load_bytes();
        read_word(0, 16'h0201);
        read_word(1, 16'h0403);

        bq = '{8'hAA, 8'hBB, 8'hCC};
        load_bytes();
        read_word(0, 16'hBBAA);
        read_word(1, 16'h00CC);

        bq.delete();
        for (int i = 0; i < 32; i++) bq.push_back(i[7:0]);
        load_bytes();
        read_word(5, 16'h0B0A);
        read_word(15, 16'h1F1E);
        read_word(16, 16'h0000);
        run_prog(1'b1, 5, -1, 200);

        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(8'h10 + i[7:0]);
        load_bytes();
        run_prog(1'b1, -1, -1, 200);
        run_prog(1'b1, -1, -1, 200);

        if (TMO_EN) begin
            run_prog(1'b0, -1, -1, 200);
        end else begin
            run_prog(1'b0, -1, -1, 100);
            @(negedge clk); run_abort = 1'b1;
            @(negedge clk); run_abort = 1'b0;
            chk("stop_state", 32'(state), 32'(HALTED));
            chk("stop_cause", 32'(halt_cause), 32'(CAUSE_ABORT));
        end

        run_prog(1'b0, 2, 2, 200);

        bq.delete();
        for (int i = 0; i < 40; i++) bq.push_back(8'h80 + i[7:0]);
        load_bytes();
        read_word(15, 16'h9F9E);

        @(negedge clk); load_start = 1'b1;
        @(negedge clk); load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = 8'h55; ld_last = 1'b0;
            @(negedge clk);
        end
        ld_valid = 1'b0;
        chk("midload_len", 32'(prog_len), 32'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rstload_len", 32'(prog_len), 32'd0);
        chk("rstload_state", 32'(state), 32'(IDLE));
        chk("rstload_ready", 32'(ld_ready), 32'd0);
        chk("rstload_proc_rst", 32'(proc_rst), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
